seq_divider: RTL and testbench

Sequential restoring divider for unsigned operands. It computes quotient and remainder one bit per clock, and is the inverse of the team's combinational array multiplier. Operands enter through a valid/ready input handshake and results leave through a valid/ready output handshake, so the block can sit directly behind or in front of the multiplier in lab datapaths. Division by zero is detected and flagged without entering the iteration loop.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 46 ++++
 rtl/seq_divider.sv | 105 ++++++++++
 tb/tb_seq_divider.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIV_WIDTH = 4;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// the divisor with a ripple of full adders, keep or restore the partial remainder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   divisor_n;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] carry;

  assign shifted   = {rem_i, bit_i};
  assign divisor_n = ~{1'b0, divisor_i};
  assign carry[0]  = 1'b1;

  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
    full_adder u_fa (
      .a_i(shifted[gi]),
      .b_i(divisor_n[gi]),
      .c_i(carry[gi]),
      .s_o(diff[gi]),
      .c_o(carry[gi+1])
    );
  end

  // With remainder < divisor the no-borrow carry and the clear trial MSB always agree.
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = carry[WIDTH+1] ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both sides and divide-by-zero short-circuit.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] divisor_q;
  logic             dbz_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] rem_d;
  logic             q_bit_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .bit_i    (quot_q[WIDTH-1]),
    .divisor_i(divisor_q),
    .rem_o    (rem_d),
    .q_bit_o  (q_bit_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            divisor_q  <= in_divisor;
            in_ready_q <= 1'b0;
            if (in_divisor == '0) begin
              quot_q      <= '1;
              rem_q       <= in_dividend;
              dbz_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              quot_q  <= in_dividend;
              rem_q   <= '0;
              dbz_q   <= 1'b0;
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          // The quotient register doubles as the dividend shifter: MSB out, result bit in.
          rem_q  <= rem_d;
          quot_q <= {quot_q[WIDTH-2:0], q_bit_d};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_quotient    = quot_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results, a monitor
// pops and compares them on every output handshake.
module tb_seq_divider;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_dividend    (in_dividend),
    .in_divisor     (in_divisor),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_quotient   (out_quotient),
    .out_remainder  (out_remainder),
    .out_div_by_zero(out_div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   handshakes = 0;
  bit   rand_ready = 1'b0;
  time  last_hs = 0;
  time  last_acc = 0;

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic d);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dbz = d;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a handshake takes place at the next rising edge when both are high here.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (out_quotient !== e.q || out_remainder !== e.r || out_div_by_zero !== e.dbz) begin
          failures++;
          $display("FAIL result: got q=%0d r=%0d dbz=%0d expected q=%0d r=%0d dbz=%0d",
                   out_quotient, out_remainder, out_div_by_zero, e.q, e.r, e.dbz);
        end else begin
          $display("txn q=%0d r=%0d dbz=%0d", out_quotient, out_remainder, out_div_by_zero);
        end
      end
      handshakes++;
      last_hs = $time + 5;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    bit done;
    done = 1'b0;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        last_acc = $time;
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int  n;
    int  hs0;
    logic seen;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", out_quotient, 0);
    chk("rst_remainder", out_remainder, 0);
    chk("rst_dbz", out_div_by_zero, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 13 / 4
    out_ready = 1'b1;
    do_op(4'd13, 4'd4, mk(4'd3, 4'd1, 1'b0));
    wait_valid(n);
    chk("lat_13_4", n, W);
    @(posedge clk);
    #1;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);

    // 15 / 1 then 3 / 7 back to back
    do_op(4'd15, 4'd1, mk(4'd15, 4'd0, 1'b0));
    do_op(4'd3, 4'd7, mk(4'd0, 4'd3, 1'b0));
    chk("b2b_accept_after_hs", last_acc > last_hs, 1);
    wait_valid(n);
    chk("lat_3_7", n, W);
    @(posedge clk);
    #1;

    // 9 / 0
    do_op(4'd9, 4'd0, mk(4'd15, 4'd9, 1'b1));
    wait_valid(n);
    chk("lat_div0", n, 0);
    @(posedge clk);
    #1;

    // 14 / 3 with backpressure
    out_ready = 1'b0;
    do_op(4'd14, 4'd3, mk(4'd4, 4'd2, 1'b0));
    wait_valid(n);
    chk("lat_14_3", n, W);
    hs0 = handshakes;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_quotient", out_quotient, 4);
      chk("bp_remainder", out_remainder, 2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_one_handshake", handshakes, hs0 + 1);
    chk("bp_valid_dropped", out_valid, 0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset during the second CALC cycle of 12 / 5
    do_op(4'd12, 4'd5, mk(4'd2, 4'd2, 1'b0));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_quotient", out_quotient, 0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("midrst_no_valid", seen, 0);
    @(posedge clk);
    #1;
    do_op(4'd12, 4'd5, mk(4'd2, 4'd2, 1'b0));
    wait_valid(n);
    chk("lat_12_5", n, W);
    @(posedge clk);
    #1;

    // All operand pairs with random output backpressure
    rand_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) do_op(W'(a), W'(b), mk(4'hF, W'(a), 1'b1));
        else        do_op(W'(a), W'(b), mk(W'(a / b), W'(a % b), 1'b0));
      end
    end
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(posedge clk);
    chk("sweep_drained", exp_q.size(), 0);
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
